pixel_stream_unpacker: RTL and testbench



---
 rtl/pixel_stream_unpacker.sv | 294 +++++++++++++++++++++++++++++
 tb/tb_pixel_stream_unpacker.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_stream_unpacker.sv
// pixel_stream_unpacker: unpacks 4-pixels-per-3-words RGB AXI-Stream into
// one pixel per cycle with x/y, framing checks. Option: PIXEL_CHECKSUM_EN.
module pixel_stream_unpacker #(
  parameter int X_SIZE = 640,
  parameter int Y_SIZE = 480
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic [31:0] in_stream_tdata,
  input  logic [3:0]  in_stream_tkeep,
  input  logic        in_stream_tlast,
  input  logic        in_stream_tuser,
  input  logic        in_stream_tvalid,
  output logic        in_stream_tready,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [7:0]  pix_r,
  output logic [7:0]  pix_g,
  output logic [7:0]  pix_b,
  output logic [9:0]  pix_x,
  output logic [8:0]  pix_y,
  output logic        pix_sof,
  output logic        pix_eol,
  output logic [15:0] frame_count,
  output logic [15:0] line_err_count,
  output logic [15:0] sof_err_count
`ifdef PIXEL_CHECKSUM_EN
  ,
  output logic [31:0] frame_checksum
`endif
);

  localparam logic [9:0] XL = 10'(X_SIZE - 1);
  localparam logic [8:0] YL = 9'(Y_SIZE - 1);

  // Coordinate following (x,y) in raster order, packed as {y,x}.
  function automatic logic [18:0] adv(input logic [9:0] x,
                                      input logic [8:0] y);
    if (x == XL) return {(y == YL) ? 9'd0 : y + 9'd1, 10'd0};
    return {y, x + 10'd1};
  endfunction

  logic        unused_tkeep;
  assign unused_tkeep = ^in_stream_tkeep;

  logic        free;
  logic        accept;
  logic        pop;
  logic        realign;
  logic [1:0]  phase_q;
  logic [1:0]  phase_d;
  logic [1:0]  ph;
  logic [15:0] carry_q;
  logic [15:0] carry_d;
  logic        pend_q;
  logic        pend_d;
  logic [23:0] pend_pix_q;
  logic [23:0] pend_pix_d;
  logic [9:0]  pend_x_q;
  logic [9:0]  pend_x_d;
  logic [8:0]  pend_y_q;
  logic [8:0]  pend_y_d;
  logic [9:0]  nx_q;
  logic [9:0]  nx_d;
  logic [8:0]  ny_q;
  logic [8:0]  ny_d;
  logic        vld_q;
  logic        vld_d;
  logic [23:0] pix_q;
  logic [23:0] pix_d;
  logic [9:0]  px_q;
  logic [9:0]  px_d;
  logic [8:0]  py_q;
  logic [8:0]  py_d;
  logic        sof_q;
  logic        sof_d;
  logic        eol_q;
  logic        eol_d;
  logic [15:0] fcnt_q;
  logic [15:0] fcnt_d;
  logic [15:0] lerr_q;
  logic [15:0] lerr_d;
  logic [15:0] serr_q;
  logic [15:0] serr_d;
  logic        ld;
  logic [23:0] ld_pix;
  logic [9:0]  ld_x;
  logic [8:0]  ld_y;
  logic [9:0]  cx;
  logic [8:0]  cy;
  logic [18:0] n1;
  logic [18:0] n2;
  logic        last_exp;
  logic        lerr_inc;
  logic        serr_inc;
  logic        last_px;

  // Handshake outputs: only registered state and pix_ready feed tready.
  always_comb begin
    free             = !vld_q || pix_ready;
    in_stream_tready = free && !pend_q && !areset;
  end

  assign accept = in_stream_tvalid && in_stream_tready;
  assign pop    = free && pend_q;

  // Word phase next state; tuser forces phase 0, a bad tlast realigns.
  always_comb begin
    phase_d = phase_q;
    if (accept) begin
      if (realign || ph == 2'd2) phase_d = 2'd0;
      else                       phase_d = ph + 2'd1;
    end
  end

  // Word phase register.
  always_ff @(posedge aclk) begin
    if (areset) phase_q <= 2'd0;
    else        phase_q <= phase_d;
  end

  // Unpack, coordinate tracking, framing checks and output register load.
  always_comb begin
    ph       = in_stream_tuser ? 2'd0 : phase_q;
    cx       = in_stream_tuser ? 10'd0 : nx_q;
    cy       = in_stream_tuser ? 9'd0 : ny_q;
    n1       = adv(cx, cy);
    n2       = adv(n1[9:0], n1[18:10]);
    last_exp = (ph == 2'd2) && (n1[9:0] == XL);
    realign  = in_stream_tlast && !last_exp;

    carry_d    = carry_q;
    pend_d     = pend_q;
    pend_pix_d = pend_pix_q;
    pend_x_d   = pend_x_q;
    pend_y_d   = pend_y_q;
    nx_d       = nx_q;
    ny_d       = ny_q;
    ld         = 1'b0;
    ld_pix     = 24'd0;
    ld_x       = 10'd0;
    ld_y       = 9'd0;
    lerr_inc   = 1'b0;
    serr_inc   = 1'b0;

    if (pop) begin
      ld     = 1'b1;
      ld_pix = pend_pix_q;
      ld_x   = pend_x_q;
      ld_y   = pend_y_q;
      pend_d = 1'b0;
    end else if (accept) begin
      // pend is always empty here, so an SOF never has a D pixel to drop.
      ld           = 1'b1;
      ld_x         = cx;
      ld_y         = cy;
      {ny_d, nx_d} = n1;
      serr_inc     = in_stream_tuser
                   ? (phase_q != 2'd0 || nx_q != 10'd0 || ny_q != 9'd0)
                   : (nx_q == 10'd0 && ny_q == 9'd0);
      unique case (1'b1)
        (ph == 2'd0): begin
          ld_pix  = in_stream_tdata[23:0];
          carry_d = {8'd0, in_stream_tdata[31:24]};
        end
        (ph == 2'd1): begin
          ld_pix  = {in_stream_tdata[15:0], carry_q[7:0]};
          carry_d = in_stream_tdata[31:16];
        end
        default: begin
          ld_pix       = {in_stream_tdata[7:0], carry_q};
          pend_d       = 1'b1;
          pend_pix_d   = in_stream_tdata[31:8];
          pend_x_d     = n1[9:0];
          pend_y_d     = n1[18:10];
          {ny_d, nx_d} = n2;
        end
      endcase
      lerr_inc = in_stream_tlast != last_exp;
      if (realign) begin
        nx_d = 10'd0;
        ny_d = (cy == YL) ? 9'd0 : cy + 9'd1;
      end
    end

    last_px = (ld_x == XL) && (ld_y == YL);
    vld_d   = vld_q && !pix_ready;
    pix_d   = pix_q;
    px_d    = px_q;
    py_d    = py_q;
    sof_d   = sof_q;
    eol_d   = eol_q;
    if (ld) begin
      vld_d = 1'b1;
      pix_d = ld_pix;
      px_d  = ld_x;
      py_d  = ld_y;
      sof_d = (ld_x == 10'd0) && (ld_y == 9'd0);
      eol_d = ld_x == XL;
    end

    fcnt_d = fcnt_q + {15'd0, ld && last_px};
    lerr_d = lerr_q + {15'd0, lerr_inc && lerr_q != 16'hFFFF};
    serr_d = serr_q + {15'd0, serr_inc && serr_q != 16'hFFFF};
  end

  // Datapath, output register and counter state.
  always_ff @(posedge aclk) begin
    if (areset) begin
      carry_q    <= 16'd0;
      pend_q     <= 1'b0;
      pend_pix_q <= 24'd0;
      pend_x_q   <= 10'd0;
      pend_y_q   <= 9'd0;
      nx_q       <= 10'd0;
      ny_q       <= 9'd0;
      vld_q      <= 1'b0;
      pix_q      <= 24'd0;
      px_q       <= 10'd0;
      py_q       <= 9'd0;
      sof_q      <= 1'b0;
      eol_q      <= 1'b0;
      fcnt_q     <= 16'd0;
      lerr_q     <= 16'd0;
      serr_q     <= 16'd0;
    end else begin
      carry_q    <= carry_d;
      pend_q     <= pend_d;
      pend_pix_q <= pend_pix_d;
      pend_x_q   <= pend_x_d;
      pend_y_q   <= pend_y_d;
      nx_q       <= nx_d;
      ny_q       <= ny_d;
      vld_q      <= vld_d;
      pix_q      <= pix_d;
      px_q       <= px_d;
      py_q       <= py_d;
      sof_q      <= sof_d;
      eol_q      <= eol_d;
      fcnt_q     <= fcnt_d;
      lerr_q     <= lerr_d;
      serr_q     <= serr_d;
    end
  end

`ifdef PIXEL_CHECKSUM_EN
  logic [31:0] acc_q;
  logic [31:0] acc_d;
  logic [31:0] acc_base;
  logic [31:0] csum_q;
  logic [31:0] csum_d;

  // Frame sum: restarts on SOF, latched and cleared on the last pixel.
  always_comb begin
    acc_base = (accept && in_stream_tuser) ? 32'd0 : acc_q;
    acc_d    = acc_q;
    csum_d   = csum_q;
    if (ld) begin
      if (last_px) begin
        csum_d = acc_base + {8'd0, ld_pix};
        acc_d  = 32'd0;
      end else begin
        acc_d  = acc_base + {8'd0, ld_pix};
      end
    end
  end

  // Checksum state.
  always_ff @(posedge aclk) begin
    if (areset) begin
      acc_q  <= 32'd0;
      csum_q <= 32'd0;
    end else begin
      acc_q  <= acc_d;
      csum_q <= csum_d;
    end
  end

  assign frame_checksum = csum_q;
`endif

  assign pix_valid      = vld_q;
  assign pix_r          = pix_q[23:16];
  assign pix_g          = pix_q[15:8];
  assign pix_b          = pix_q[7:0];
  assign pix_x          = px_q;
  assign pix_y          = py_q;
  assign pix_sof        = sof_q;
  assign pix_eol        = eol_q;
  assign frame_count    = fcnt_q;
  assign line_err_count = lerr_q;
  assign sof_err_count  = serr_q;

endmodule

// File: tb/tb_pixel_stream_unpacker.sv
// tb_pixel_stream_unpacker: random packed frames against a raster-order
// pixel model; small 8x4 frame geometry.
module tb_pixel_stream_unpacker;
  localparam int X = 8;
  localparam int Y = 4;

  logic        aclk = 1'b0;
  logic        areset;
  logic [31:0] tdata;
  logic [3:0]  tkeep;
  logic        tlast;
  logic        tuser;
  logic        tvalid;
  logic        tready;
  logic        pix_valid;
  logic        pix_ready;
  logic [7:0]  pix_r;
  logic [7:0]  pix_g;
  logic [7:0]  pix_b;
  logic [9:0]  pix_x;
  logic [8:0]  pix_y;
  logic        pix_sof;
  logic        pix_eol;
  logic [15:0] frame_count;
  logic [15:0] line_err_count;
  logic [15:0] sof_err_count;
`ifdef PIXEL_CHECKSUM_EN
  logic [31:0] frame_checksum;
`endif

  always #5 aclk = ~aclk;

  pixel_stream_unpacker #(.X_SIZE(X), .Y_SIZE(Y)) dut (
    .aclk(aclk),
    .areset(areset),
    .in_stream_tdata(tdata),
    .in_stream_tkeep(tkeep),
    .in_stream_tlast(tlast),
    .in_stream_tuser(tuser),
    .in_stream_tvalid(tvalid),
    .in_stream_tready(tready),
    .pix_valid(pix_valid),
    .pix_ready(pix_ready),
    .pix_r(pix_r),
    .pix_g(pix_g),
    .pix_b(pix_b),
    .pix_x(pix_x),
    .pix_y(pix_y),
    .pix_sof(pix_sof),
    .pix_eol(pix_eol),
    .frame_count(frame_count),
    .line_err_count(line_err_count),
    .sof_err_count(sof_err_count)
`ifdef PIXEL_CHECKSUM_EN
    ,
    .frame_checksum(frame_checksum)
`endif
  );

  typedef struct {
    logic [31:0] d;
    bit          lst;
    bit          usr;
    bit          p2;
  } wd_t;

  typedef struct {
    logic [23:0] p;
    int          x;
    int          y;
  } px_t;

  wd_t         wq[$];
  px_t         eq[$];
  int          ncmp = 0;
  int          nerr = 0;
  logic [31:0] esum;

  // Packer model: 4 pixels -> 3 words, LSB-first byte stream.
  task automatic push_group(input int y, input int x0,
                            input bit usr, input bit lst);
    logic [23:0] p[4];
    for (int i = 0; i < 4; i++) begin
      p[i] = 24'($urandom);
      esum += {8'd0, p[i]};
      eq.push_back('{p[i], x0 + i, y});
    end
    wq.push_back('{{p[1][7:0], p[0]}, 1'b0, usr, 1'b0});
    wq.push_back('{{p[2][15:0], p[1][23:8]}, 1'b0, 1'b0, 1'b0});
    wq.push_back('{{p[3], p[2][23:16]}, lst, 1'b0, 1'b1});
  endtask

  task automatic push_line(input int y, input int n,
                           input bit usr, input bit lst);
    for (int g = 0; g < n / 4; g++)
      push_group(y, 4 * g, usr && g == 0, lst && g == n / 4 - 1);
  endtask

  task automatic push_frame(input bit usr);
    esum = 32'd0;
    for (int y = 0; y < Y; y++) push_line(y, X, usr && y == 0, 1'b1);
  endtask

  task automatic do_reset();
    areset    = 1'b1;
    tvalid    = 1'b0;
    tuser     = 1'b0;
    tlast     = 1'b0;
    pix_ready = 1'b1;
    repeat (2) @(posedge aclk);
    #1 areset = 1'b0;
  endtask

  // Drives wq, consumes eq; checks order, hold-while-stalled, D gap.
  task automatic run(input bit tog, input bit gaps, input int budget,
                     output int cyc);
    wd_t         cur;
    px_t         e;
    bit          inf;
    bit          outf;
    bit          gapn;
    bit          hv;
    logic [45:0] obs;
    logic [45:0] held;
    logic [45:0] ex;
    cyc       = 0;
    gapn      = 0;
    hv        = 0;
    held      = '0;
    pix_ready = 1'b1;
    tvalid    = 1'b0;
    if (wq.size() > 0) begin
      cur    = wq.pop_front();
      tdata  = cur.d;
      tlast  = cur.lst;
      tuser  = cur.usr;
      tvalid = 1'b1;
    end
    while ((tvalid || wq.size() > 0 || eq.size() > 0) && cyc < budget) begin
      @(negedge aclk);
      inf  = tvalid && tready;
      outf = pix_valid && pix_ready;
      obs  = {pix_valid, pix_r, pix_g, pix_b, pix_x, pix_y, pix_sof, pix_eol};
      if (gapn) begin
        ncmp++;
        if (tready !== 1'b0) begin
          nerr++;
          $display("FAIL pend_gap: tready=%b want 0", tready);
        end
        gapn = 0;
      end
      if (hv) begin
        ncmp++;
        if (obs !== held) begin
          nerr++;
          $display("FAIL stall_hold: got %h want %h", obs, held);
        end
        hv = 0;
      end
      if (outf) begin
        ncmp++;
        if (eq.size() == 0) begin
          nerr++;
          $display("FAIL extra_pixel: got %h want none", obs);
        end else begin
          e  = eq.pop_front();
          ex = {1'b1, e.p, 10'(e.x), 9'(e.y),
                e.x == 0 && e.y == 0, e.x == X - 1};
          if (obs !== ex) begin
            nerr++;
            $display("FAIL pixel: got %h want %h", obs, ex);
          end
        end
      end
      if (pix_valid && !pix_ready) begin
        held = obs;
        hv   = 1;
      end
      if (inf && cur.p2) gapn = 1;
      @(posedge aclk);
      #1;
      if (inf || !tvalid) begin
        if (wq.size() > 0 && (!gaps || $urandom_range(3) != 0)) begin
          cur    = wq.pop_front();
          tdata  = cur.d;
          tlast  = cur.lst;
          tuser  = cur.usr;
          tvalid = 1'b1;
        end else begin
          tvalid = 1'b0;
          tlast  = 1'b0;
          tuser  = 1'b0;
        end
      end
      pix_ready = tog ? !pix_ready : 1'b1;
      cyc++;
    end
    tvalid = 1'b0;
    ncmp++;
    if (cyc >= budget) begin
      nerr++;
      $display("FAIL timeout: cycles=%0d want <%0d left=%0d", cyc, budget,
               eq.size());
      wq.delete();
      eq.delete();
    end
    pix_ready = 1'b1;
    @(negedge aclk);
    ncmp++;
    if (pix_valid !== 1'b0) begin
      nerr++;
      $display("FAIL drained: pix_valid=%b want 0", pix_valid);
    end
  endtask

  task automatic test_reset();
    areset    = 1'b1;
    tvalid    = 1'b0;
    tuser     = 1'b0;
    tlast     = 1'b0;
    tdata     = 32'd0;
    pix_ready = 1'b1;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    ncmp++;
    if ({tready, pix_valid, pix_r, pix_g, pix_b, pix_x, pix_y, pix_sof,
         pix_eol, frame_count, line_err_count, sof_err_count} !== '0) begin
      nerr++;
      $display("FAIL reset_outputs: tready=%b valid=%b x=%h y=%h fc=%h",
               tready, pix_valid, pix_x, pix_y, frame_count);
    end
`ifdef PIXEL_CHECKSUM_EN
    ncmp++;
    if (frame_checksum !== 32'd0) begin
      nerr++;
      $display("FAIL reset_checksum: got %h want 0", frame_checksum);
    end
`endif
    @(posedge aclk);
    #1 areset = 1'b0;
    @(negedge aclk);
    ncmp++;
    if (tready !== 1'b1) begin
      nerr++;
      $display("FAIL ready_after_reset: got %b want 1", tready);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge aclk);
      ncmp++;
      if (pix_valid !== 1'b0) begin
        nerr++;
        $display("FAIL idle_valid: got %b want 0", pix_valid);
      end
    end
  endtask

  task automatic check_counts(input string nm, input int fc, input int le,
                              input int se);
    ncmp++;
    if ({frame_count, line_err_count, sof_err_count} !==
        {16'(fc), 16'(le), 16'(se)}) begin
      nerr++;
      $display("FAIL %s_counts: got fc=%0d le=%0d se=%0d want %0d/%0d/%0d",
               nm, frame_count, line_err_count, sof_err_count, fc, le, se);
    end
`ifdef PIXEL_CHECKSUM_EN
    if (fc != 0) begin
      ncmp++;
      if (frame_checksum !== esum) begin
        nerr++;
        $display("FAIL %s_checksum: got %h want %h", nm, frame_checksum,
                 esum);
      end
    end
`endif
  endtask

  task automatic test_single_group();
    int c;
    do_reset();
    wq.push_back('{32'h44332211, 1'b0, 1'b1, 1'b0});
    wq.push_back('{32'h88776655, 1'b0, 1'b0, 1'b0});
    wq.push_back('{32'hCCBBAA99, 1'b0, 1'b0, 1'b1});
    eq.push_back('{24'h332211, 0, 0});
    eq.push_back('{24'h665544, 1, 0});
    eq.push_back('{24'h998877, 2, 0});
    eq.push_back('{24'hCCBBAA, 3, 0});
    run(1'b0, 1'b0, 50, c);
    check_counts("single", 0, 0, 0);
  endtask

  task automatic test_frame();
    int c;
    do_reset();
    push_frame(1'b1);
    run(1'b0, 1'b0, 500, c);
    check_counts("frame", 1, 0, 0);
  endtask

  task automatic test_back_to_back();
    int c;
    do_reset();
    push_frame(1'b1);
    push_frame(1'b1);
    run(1'b0, 1'b0, 500, c);
    ncmp++;
    if (c > 2 * (X * Y) + 4) begin
      nerr++;
      $display("FAIL throughput: cycles=%0d want <=%0d", c, 2 * X * Y + 4);
    end
    check_counts("b2b", 2, 0, 0);
  endtask

  task automatic test_early_tlast();
    int c;
    do_reset();
    esum = 32'd0;
    push_line(0, 4, 1'b1, 1'b1);
    for (int y = 1; y < Y; y++) push_line(y, X, 1'b0, 1'b1);
    run(1'b0, 1'b0, 500, c);
    check_counts("early_tlast", 1, 1, 0);
  endtask

  task automatic test_missing_tlast();
    int c;
    do_reset();
    esum = 32'd0;
    push_line(0, X, 1'b1, 1'b0);
    for (int y = 1; y < Y; y++) push_line(y, X, 1'b0, 1'b1);
    run(1'b0, 1'b0, 500, c);
    check_counts("missing_tlast", 1, 1, 0);
  endtask

  task automatic test_ready_toggle();
    int c;
    do_reset();
    push_frame(1'b1);
    run(1'b1, 1'b1, 1000, c);
    check_counts("toggle", 1, 0, 0);
  endtask

  task automatic test_sof_mid_line();
    int          c;
    logic [31:0] w;
    do_reset();
    push_line(0, 4, 1'b1, 1'b0);
    w = $urandom;
    wq.push_back('{w, 1'b0, 1'b0, 1'b0});
    eq.push_back('{w[23:0], 4, 0});
    push_frame(1'b1);
    run(1'b0, 1'b0, 500, c);
    check_counts("sof_mid", 1, 0, 1);
  endtask

  task automatic test_missing_sof();
    int c;
    do_reset();
    push_frame(1'b0);
    run(1'b0, 1'b1, 800, c);
    check_counts("missing_sof", 1, 0, 1);
  endtask

  initial begin
    tkeep = 4'hF;
    test_reset();
    test_single_group();
    test_frame();
    test_back_to_back();
    test_early_tlast();
    test_missing_tlast();
    test_ready_toggle();
    test_sof_mid_line();
    test_missing_sof();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
